uart_packet_tx: RTL

- Parametrised packet transmitter: latches up to MAX_BYTES payload bytes on a start pulse and sends them back to back over a single UART line.
- Contains its own baud generator running off clk_50M, so no derived bit clock is needed.
- Adds what the earlier fixed 14-byte sender lacked: runtime packet length, selectable parity, optional inter-byte gap, optional trailing checksum byte, and busy/done handshake outputs.
- Sits between the controller/sensor logic and the board UART pin.

---
 rtl/uart_packet_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_packet_tx.sv
// Packet UART transmitter: latches up to MAX_BYTES payload bytes on start and
// sends them back to back with optional parity, inter-frame gap and checksum.
module uart_packet_tx #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int MAX_BYTES = 16,
  parameter int GAP_BITS  = 0,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LW-1:0]            len,
  input  logic [8*MAX_BYTES-1:0]   data_flat,
  input  logic [1:0]               parity_mode,
  input  logic                     append_csum,
  output logic                     busy,
  output logic                     done,
  output logic [LW-1:0]            byte_idx,
  output logic                     tx
);

  localparam int              DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [LW-1:0]   MAX_LEN  = LW'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [LW-1:0]       frame_q, frame_d;
  logic [LW-1:0]       eff_len_q, eff_len_d;
  logic                csum_en_q, csum_en_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic [8*MAX_BYTES-1:0] data_q;

  logic                accept;
  logic                bit_end;
  logic                parity_on;
  logic                is_payload;
  logic                last_frame;
  logic [7:0]          cur_byte;
  logic [LW-1:0]       len_clamped;
  logic [LW:0]         n_frames;

  assign bit_end    = (div_q == DIV_LAST);
  assign parity_on  = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign is_payload = (frame_q < eff_len_q);
  assign n_frames   = {1'b0, eff_len_q} + {{LW{1'b0}}, csum_en_q};
  assign last_frame = (({1'b0, frame_q} + (LW + 1)'(1)) == n_frames);
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  // Byte for the current frame: a latched payload byte, or the running checksum.
  always_comb begin
    cur_byte = csum_q;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (is_payload && frame_q == LW'(k)) cur_byte = data_q[8*k +: 8];
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    eff_len_d = eff_len_q;
    csum_en_d = csum_en_q;
    mode_d    = mode_q;
    csum_d    = csum_q;
    shift_d   = shift_q;
    par_d     = par_q;
    accept    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          accept    = 1'b1;
          eff_len_d = len_clamped;
          csum_en_d = append_csum;
          mode_d    = parity_mode;
          csum_d    = '0;
          frame_d   = '0;
          div_d     = '0;
          bit_d     = '0;
          state_d   = (len_clamped == '0 && !append_csum) ? S_DONE : S_START;
        end
      end
      default: begin
        div_d = bit_end ? '0 : div_q + DW'(1);
        if (bit_end) begin
          case (state_q)
            S_START: begin
              shift_d = cur_byte;
              par_d   = (^cur_byte) ^ (mode_q == 2'b10);
              if (is_payload) csum_d = csum_q + cur_byte;
              bit_d   = '0;
              state_d = S_DATA;
            end
            S_DATA: begin
              if (bit_q == 4'd7) begin
                state_d = parity_on ? S_PARITY : S_STOP;
              end else begin
                bit_d   = bit_q + 4'd1;
                shift_d = shift_q >> 1;
              end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
              if (last_frame) begin
                state_d = S_DONE;
              end else if (GAP_BITS > 0) begin
                bit_d   = '0;
                state_d = S_GAP;
              end else begin
                frame_d = frame_q + LW'(1);
                state_d = S_START;
              end
            end
            S_GAP: begin
              if (bit_q == GAP_LAST) begin
                frame_d = frame_q + LW'(1);
                state_d = S_START;
              end else begin
                bit_d = bit_q + 4'd1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // The line level is registered from the next state so the pin never glitches.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      eff_len_q <= '0;
      csum_en_q <= 1'b0;
      mode_q    <= 2'b00;
      csum_q    <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      eff_len_q <= eff_len_d;
      csum_en_q <= csum_en_d;
      mode_q    <= mode_d;
      csum_q    <= csum_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  // NOTE: the payload store has no reset; it is always written on acceptance before use.
  always_ff @(posedge clk_50M) begin
    if (accept) data_q <= data_flat;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign byte_idx = frame_q;

endmodule
